// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the execute-stage ALU.
// Opcode encodings (single-cycle and RV32M), the handshake FSM state type,
// and the default control-field width.
package alu_multicycle_pkg;

  localparam int CTRL_W_DEF = 5;
  typedef logic [CTRL_W_DEF-1:0] op_t;

  // Single-cycle ops
  localparam op_t OPAND    = 5'd0;
  localparam op_t OPOR     = 5'd1;
  localparam op_t OPADD    = 5'd2;
  localparam op_t OPSUB    = 5'd6;
  localparam op_t OPSLT    = 5'd7;
  localparam op_t OPLUI    = 5'd8;
  localparam op_t OPSLTU   = 5'd9;
  localparam op_t ZERO     = 5'd31;

  // Iterative multiply / divide
  localparam op_t OPMUL    = 5'd16;
  localparam op_t OPMULH   = 5'd17;
  localparam op_t OPMULHSU = 5'd18;
  localparam op_t OPMULHU  = 5'd19;
  localparam op_t OPDIV    = 5'd20;
  localparam op_t OPDIVU   = 5'd21;
  localparam op_t OPREM    = 5'd22;
  localparam op_t OPREMU   = 5'd23;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

endpackage

// File: rtl/alu_multicycle_muldiv_iter.sv
// Iterative radix-2 multiply/divide engine on operand magnitudes.
// Ports: clk/rst (sync, active-high); start latches a/b and op select;
// is_div selects divide, sel_hi selects high product half or remainder;
// a_signed/b_signed give operand signedness; last is high on the final
// CALC step; done is high for the FIX cycle, when result is valid.
module alu_multicycle_muldiv_iter
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             sel_hi,
  input  logic             a_signed,
  input  logic             b_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  state_e           phase;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, q, m;
  logic             neg, div_q, hi_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, shl, diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  assign a_neg = a_signed & a[WIDTH-1];
  assign b_neg = b_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply: {acc,q} shifts right, adding m when the multiplier LSB is set.
  // Divide: {acc,q} shifts left, restoring when the trial subtract borrows.
  assign sum  = {1'b0, acc} + {1'b0, m};
  assign shl  = {acc, q[WIDTH-1]};
  assign diff = shl - {1'b0, m};

  assign last = (phase == CALC) && (cnt == CW'(WIDTH-1));
  assign done = (phase == FIX);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= IDLE;
      cnt   <= '0;
    end else if (start) begin
      phase <= CALC;
      cnt   <= '0;
      acc   <= '0;
      div_q <= is_div;
      hi_q  <= sel_hi;
      // Remainder follows the dividend sign; everything else is sign XOR.
      neg   <= (is_div & sel_hi) ? a_neg : (a_neg ^ b_neg);
      q     <= is_div ? a_mag : b_mag;
      m     <= is_div ? b_mag : a_mag;
    end else begin
      case (phase)
        CALC: begin
          cnt <= cnt + 1'b1;
          if (div_q) begin
            if (!diff[WIDTH]) begin
              acc <= diff[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
              acc <= shl[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b0};
            end
          end else if (q[0]) begin
            {acc, q} <= {sum, q[WIDTH-1:1]};
          end else begin
            {acc, q} <= {1'b0, acc, q[WIDTH-1:1]};
          end
          if (last) phase <= FIX;
        end
        FIX:     phase <= IDLE;
        default: phase <= IDLE;
      endcase
    end
  end

  assign prod   = {acc, q};
  assign prod_s = neg ? -prod : prod;
  assign quo_s  = neg ? -q : q;
  assign rem_s  = neg ? -acc : acc;

  always_comb begin
    result = '0;
    if (div_q) result = hi_q ? rem_s : quo_s;
    else       result = hi_q ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with registered result and valid/ready handshake.
// Single-cycle logic/arithmetic ops and divide special cases complete one
// cycle after accept; RV32M mul/div/rem run through the iterative engine.
// Ports: iCLK, iRST (sync, active-high); iValid/oReady request handshake;
// iControl opcode, iA/iB operands; oValid one-cycle completion pulse;
// oResult registered result; oZero flags oResult == 0.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iValid,
  output logic              oReady,
  input  logic [CTRL_W-1:0] iControl,
  input  logic [WIDTH-1:0]  iA,
  input  logic [WIDTH-1:0]  iB,
  output logic              oValid,
  output logic [WIDTH-1:0]  oResult,
  output logic              oZero
);

  state_e           state, state_d;
  logic             load, start;
  logic [WIDTH-1:0] res_d, fast_res, md_result;
  logic             md_last, md_done;

  logic op_mul, op_mulh, op_mulhsu, op_mulhu, op_div, op_divu, op_rem, op_remu;
  logic iter, divlike, b_zero, ovf, special;

  assign op_mul    = iControl == CTRL_W'(OPMUL);
  assign op_mulh   = iControl == CTRL_W'(OPMULH);
  assign op_mulhsu = iControl == CTRL_W'(OPMULHSU);
  assign op_mulhu  = iControl == CTRL_W'(OPMULHU);
  assign op_div    = iControl == CTRL_W'(OPDIV);
  assign op_divu   = iControl == CTRL_W'(OPDIVU);
  assign op_rem    = iControl == CTRL_W'(OPREM);
  assign op_remu   = iControl == CTRL_W'(OPREMU);

  assign divlike = op_div | op_divu | op_rem | op_remu;
  assign iter    = op_mul | op_mulh | op_mulhsu | op_mulhu | divlike;
  assign b_zero  = (iB == '0);
  assign ovf     = (op_div | op_rem) && (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (&iB);
  assign special = (divlike & b_zero) | ovf;

  // Result for everything that completes on the accept edge.
  always_comb begin
    fast_res = '0;
    case (iControl)
      CTRL_W'(OPAND):  fast_res = iA & iB;
      CTRL_W'(OPOR):   fast_res = iA | iB;
      CTRL_W'(OPADD):  fast_res = iA + iB;
      CTRL_W'(OPSUB):  fast_res = iA - iB;
      CTRL_W'(OPSLT):  fast_res = {{(WIDTH-1){1'b0}}, $signed(iA) < $signed(iB)};
      CTRL_W'(OPSLTU): fast_res = {{(WIDTH-1){1'b0}}, iA < iB};
      CTRL_W'(OPLUI):  fast_res = iB;
      default:         fast_res = '0;
    endcase
    if (special) begin
      if (b_zero) fast_res = (op_div | op_divu) ? '1 : iA;
      else        fast_res = op_div ? iA : '0;   // MIN / -1 overflow
    end
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    start   = 1'b0;
    res_d   = fast_res;
    case (state)
      IDLE: if (iValid) begin
        if (iter && !special) begin
          start   = 1'b1;
          state_d = CALC;
        end else begin
          load    = 1'b1;
          state_d = DONE;
        end
      end
      CALC: if (md_last) state_d = FIX;
      FIX: if (md_done) begin
        load    = 1'b1;
        res_d   = md_result;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      oResult <= '0;
    end else begin
      state <= state_d;
      if (load) oResult <= res_d;
    end
  end

  assign oReady = (state == IDLE);
  assign oValid = (state == DONE);
  assign oZero  = (oResult == '0);

  alu_multicycle_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (iCLK),
    .rst      (iRST),
    .start    (start),
    .is_div   (divlike),
    .sel_hi   (op_mulh | op_mulhsu | op_mulhu | op_rem | op_remu),
    .a_signed (op_mulh | op_mulhsu | op_div | op_rem),
    .b_signed (op_mulh | op_div | op_rem),
    .a        (iA),
    .b        (iB),
    .last     (md_last),
    .done     (md_done),
    .result   (md_result)
  );

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;
  import alu_multicycle_pkg::*;

  localparam int W  = 32;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst, valid, ready, ovalid, zero;
  logic [CW-1:0] ctrl;
  logic [W-1:0]  a, b, res;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W), .CTRL_W(CW)) dut (
    .iCLK(clk), .iRST(rst), .iValid(valid), .oReady(ready),
    .iControl(ctrl), .iA(a), .iB(b),
    .oValid(ovalid), .oResult(res), .oZero(zero)
  );

  typedef struct {
    logic [W-1:0] res;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every completion pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ovalid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: got oValid with result %h, required no completion", res);
      end else begin
        e = sb.pop_front();
        if (res !== e.res || zero !== (e.res == '0)) begin
          n_bad++;
          $display("FAIL %s: got result %h zero %b, required %h zero %b",
                   e.name, res, zero, e.res, e.res == '0);
        end
        n_cmp++;
        if (cyc != e.due) begin
          n_bad++;
          $display("FAIL %s_latency: got cycle %0d, required %0d", e.name, cyc, e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // lat = 1 for single-cycle/special, 34 for iterative (oValid at t+lat).
  task automatic issue(input string nm, input logic [CW-1:0] op, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [W-1:0] ex, input int lat,
                       input bit track);
    int k = 0;
    @(negedge clk);
    while (!ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_ready_timeout: got oReady 0, required 1", nm);
      return;
    end
    valid = 1'b1; ctrl = op; a = ia; b = ib;
    @(posedge clk);
    #1;
    valid = 1'b0;
    if (track) sb.push_back('{ex, cyc + lat - 1, nm});
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", W'(sb.size()), '0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; ctrl = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", res, '0);
    chk("rst_ready",  W'(ready), 1);
    chk("rst_valid",  W'(ovalid), 0);
    chk("rst_zero",   W'(zero), 1);
    rst = 1'b0;

    // Single-cycle ops
    issue("add_wrap", OPADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1, 1);
    issue("sub_zero", OPSUB,  32'h5,        32'h5,        32'h0,        1, 1);
    issue("slt",      OPSLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1, 1);
    issue("sltu",     OPSLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 1);
    issue("undef",    5'd12,  32'h1234,     32'h5678,     32'h0,        1, 1);
    issue("and",      OPAND,  32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1, 1);
    issue("or",       OPOR,   32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1, 1);
    issue("lui",      OPLUI,  32'hFFFF,     32'h12345000, 32'h12345000, 1, 1);

    // Iterative ops
    issue("mul",      OPMUL,    32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB, 34, 1);
    issue("mulh",     OPMULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, 1);
    issue("mulhu",    OPMULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1);
    issue("mulhsu",   OPMULHSU, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 34, 1);
    issue("divu",     OPDIVU,   32'd100,      32'd7,        32'd14,       34, 1);
    issue("remu",     OPREMU,   32'd100,      32'd7,        32'd2,        34, 1);
    issue("div_neg",  OPDIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1);
    issue("rem_neg",  OPREM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1);
    issue("div_negb", OPDIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1);
    issue("rem_negb", OPREM,    32'd7,        32'hFFFFFFFE, 32'd1,        34, 1);

    // Special cases
    issue("div_by0",  OPDIV,  32'd7,        32'd0,        32'hFFFFFFFF, 1, 1);
    issue("rem_by0",  OPREM,  32'd7,        32'd0,        32'd7,        1, 1);
    issue("divu_by0", OPDIVU, 32'd7,        32'd0,        32'hFFFFFFFF, 1, 1);
    issue("div_ovf",  OPDIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
    issue("rem_ovf",  OPREM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        1, 1);

    // iValid held through CALC and iA changed mid-operation
    issue("mulhu_hold", OPMULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1);
    @(negedge clk);
    valid = 1'b1; ctrl = OPADD; a = 32'd1; b = 32'd2;
    repeat (5) @(negedge clk);
    a = 32'hDEAD0000;
    repeat (5) @(negedge clk);
    valid = 1'b0;
    drain();

    // Reset at CALC step ~10 aborts the operation
    issue("mul_abort", OPMUL, 32'd3, 32'd7, 32'd0, 34, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_result", res, '0);
    chk("abort_ready",  W'(ready), 1);
    chk("abort_valid",  W'(ovalid), 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue("add_after", OPADD, 32'd2, 32'd3, 32'd5, 1, 1);
    drain();

    // Reset and request on the same edge: request dropped
    @(negedge clk);
    rst = 1'b1; valid = 1'b1; ctrl = OPADD; a = 32'd9; b = 32'd9;
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    chk("rst_vs_valid_result", res, '0);
    chk("rst_vs_valid_ready",  W'(ready), 1);
    repeat (4) @(negedge clk);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised successor of the single-cycle datapath ALU.
- Keeps the existing logic/arithmetic ops, now with a registered result and a 1-cycle latency.
- Adds RV32M multiply/divide/remainder using an iterative radix-2 engine, behind a valid/ready handshake.
- Sits in the execute stage of the multicycle and pipelined cores; the control unit stalls on oReady.

Parameters:
- WIDTH, 32, operand/result width in bits (≥8).
- CTRL_W, 5, width of iControl; opcode encodings come from the shared package.

Ports:
- iCLK  in  1  clock, rising edge
- iRST  in  1  reset, synchronous, active-high
- iValid  in  1  request strobe; accepted only when oReady=1
- oReady  out  1  block idle and able to accept
- iControl  in  CTRL_W  operation code
- iA  in  WIDTH  operand A (signed for signed ops)
- iB  in  WIDTH  operand B
- oValid  out  1  one-cycle pulse: oResult is new
- oResult  out  WIDTH  registered result; held until the next completion
- oZero  out  1  (oResult == 0), combinational from the oResult register

Behaviour:
- Reset (iRST high at a clock edge):
  - state=IDLE, oResult=0, oValid=0, oReady=1, oZero=1.
  - Aborts any operation in flight; no oValid is produced for it.
- Accept rule:
  - A request is accepted on an edge where iValid=1 and oReady=1.
  - At that edge iA, iB and iControl are latched; later input changes have no effect.
  - iValid while oReady=0 is ignored and not queued.
- FSM: IDLE, CALC, FIX, DONE.
  - IDLE: oReady=1. On accept, a single-cycle op or a special-case divide goes to DONE; a MUL*/DIV*/REM* op goes to CALC with the step counter cleared.
  - CALC: one radix-2 step per cycle. Multiply is shift-add on magnitudes; divide is restoring on magnitudes. Exactly WIDTH cycles, then FIX.
  - FIX: apply the sign correction (two's-complement negation where required), select the high/low or quotient/remainder half, load oResult.
  - DONE: oValid=1 for exactly this cycle, then IDLE. oReady=0 in CALC, FIX and DONE.
- Latency, with accept at edge t:
  - Single-cycle ops: oValid high in cycle t+1.
  - Iterative ops: oValid high in cycle t+WIDTH+2, i.e. t+34 at WIDTH=32.
  - Peak throughput is one single-cycle op per 2 cycles.
- Single-cycle ops (result registered into oResult on the accept edge):
  - OPAND, OPOR: A&B, A|B.
  - OPADD, OPSUB: modulo 2^WIDTH; wrap-around, no overflow flag.
  - OPSLT: signed compare, result 1 or 0, zero-extended.
  - OPSLTU: unsigned compare.
  - OPLUI: passes B.
  - Undefined code: result 0.
- Iterative ops: OPMUL (low WIDTH bits), OPMULH (signed×signed high), OPMULHSU (signed A × unsigned B, high), OPMULHU (unsigned high), OPDIV, OPDIVU, OPREM, OPREMU.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- Special cases, detected at accept, completing in 1 cycle (oValid at t+1):
  - B=0: DIV/DIVU give all-ones; REM/REMU give A.
  - Signed overflow, A=most-negative and B=−1: DIV gives A; REM gives 0.
- Simultaneous iRST and iValid: reset wins and the request is dropped.

Decomposition:
- Shared package (extended, not duplicated):
  - Opcode constants OPAND, OPOR, OPADD, OPSUB, OPSLT, OPLUI, ZERO.
  - New OPSLTU, OPMUL, OPMULH, OPMULHSU, OPMULHU, OPDIV, OPDIVU, OPREM, OPREMU.
  - FSM state enum.
- One sub-module, muldiv_iter:
  - Owns CALC/FIX, the step counter, and the partial-product/remainder registers.
  - Interface: start/done plus signedness and op select.
- The top level keeps the single-cycle ops, special-case detection, the handshake and oResult.

Test Plan:
- OPADD 0x7FFFFFFF+0x00000001: oValid at t+1, oResult=0x80000000, oZero=0. OPSUB 5−5: oResult=0, oZero=1.
- OPSLT iA=0xFFFFFFFF, iB=1 gives 1; OPSLTU with the same operands gives 0; undefined code gives 0.
- OPMUL −3×7: oResult=0xFFFFFFEB, oValid at exactly t+34. OPMULH 0x80000000×0x80000000: oResult=0x40000000. OPMULHU 0xFFFFFFFF×0xFFFFFFFF: oResult=0xFFFFFFFE.
- OPDIVU 100/7 gives 14 and OPREMU gives 2, both at t+34. OPDIV −7/2 gives 0xFFFFFFFD (−3); OPREM gives 0xFFFFFFFF (−1).
- Special cases at t+1:
  - OPDIV 7/0 gives 0xFFFFFFFF; OPREM 7/0 gives 7.
  - OPDIV 0x80000000/0xFFFFFFFF gives 0x80000000; OPREM gives 0.
- Handshake and reset:
  - iValid held during CALC is not accepted, and exactly one oValid pulse is produced.
  - Change iA mid-CALC: result is unaffected.
  - Assert iRST at CALC step 10: no oValid, oResult=0, oReady=1 the next cycle, and a new OPADD then completes normally.
